hamming_rx_stream_decoder: RTL and testbench

//  Streaming Hamming(7,4) receive stage that sits directly downstream of the encoder/channel path.
//  - Accepts 7-bit codewords over a valid/ready handshake.
//  - Computes the syndrome, corrects any single-bit error and emits 4-bit data plus per-word flags.
//  - Two-stage registered pipeline with back-pressure; keeps a saturating count of corrected words.

---
 rtl/hamming_rx_stream_decoder.sv | 139 +++++++++++++
 tb/tb_hamming_rx_stream_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_rx_stream_decoder.sv
// rtl/hamming_rx_stream_decoder.sv - two-stage Hamming(7,4) stream decoder; HAM_ERR_CNT_EN enables corr_cnt
module hamming_rx_stream_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       data_out,
    output logic             err_flag,
    output logic [2:0]       err_pos,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt
);

    logic       s1_valid_q, s1_valid_d;
    logic [6:0] s1_code_q, s1_code_d;
    logic [2:0] s1_syn_q, s1_syn_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] data_out_q, data_out_d;
    logic       err_flag_q, err_flag_d;
    logic [2:0] err_pos_q, err_pos_d;

    logic       stall;
    logic       advance;
    logic [2:0] syn_in;
    logic [6:0] flip_mask;
    logic [6:0] fixed_code;

    // Both stages move together unless the consumer is refusing a valid word.
    assign stall    = out_valid_q & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    // Syndrome of the incoming word; S is the 1-based index of the bad bit.
    assign syn_in[0] = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6];
    assign syn_in[1] = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6];
    assign syn_in[2] = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6];

    // Stage 1: capture codeword and syndrome on accept, hold while stalled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d = code_in;
                s1_syn_d  = syn_in;
            end
        end
    end

    // One-hot correction mask selecting bit S-1; all zero for a clean word.
    always_comb begin
        flip_mask = '0;
        for (int i = 0; i < 7; i++) begin
            flip_mask[i] = (s1_syn_q == 3'(i + 1));
        end
    end

    assign fixed_code = s1_code_q ^ flip_mask;

    // Stage 2: register corrected data and flags; a stage-1 bubble clears out_valid.
    always_comb begin
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        err_flag_d  = err_flag_q;
        err_pos_d   = err_pos_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_out_d = {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
                err_flag_d = |s1_syn_q;
                err_pos_d  = s1_syn_q;
            end
        end
    end

    // Pipeline registers; reset drops any words in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_syn_q    <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            err_flag_q  <= 1'b0;
            err_pos_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            s1_syn_q    <= s1_syn_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            err_flag_q  <= err_flag_d;
            err_pos_q   <= err_pos_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign err_flag  = err_flag_q;
    assign err_pos   = err_pos_q;

`ifdef HAM_ERR_CNT_EN
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;

    // Count delivered corrected words, saturating; clear has priority.
    always_comb begin
        corr_cnt_d = corr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d = '0;
        end else if (out_valid_q && out_ready && err_flag_q && !(&corr_cnt_q)) begin
            corr_cnt_d = corr_cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            corr_cnt_q <= '0;
        end else begin
            corr_cnt_q <= corr_cnt_d;
        end
    end

    assign corr_cnt = corr_cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
`endif

endmodule

// File: tb/tb_hamming_rx_stream_decoder.sv
// tb/tb_hamming_rx_stream_decoder.sv - directed self-checking bench for hamming_rx_stream_decoder
module tb_hamming_rx_stream_decoder;

`ifdef HAM_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [6:0]  code_in;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [3:0]  data_out, data_out2;
    logic        err_flag, err_flag2;
    logic [2:0]  err_pos, err_pos2;
    logic        cnt_clr;
    logic [15:0] corr_cnt;
    logic [1:0]  corr_cnt2;

    int checks   = 0;
    int failures = 0;
    int exp1     = 0;
    int exp2     = 0;

    always #5 clk = ~clk;

    hamming_rx_stream_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .err_flag(err_flag), .err_pos(err_pos),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt)
    );

    hamming_rx_stream_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .code_in(code_in), .out_valid(out_valid2), .out_ready(out_ready),
        .data_out(data_out2), .err_flag(err_flag2), .err_pos(err_pos2),
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; code_in = '0;
        tick; tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (data_out !== 4'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", data_out); end
        checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL reset_err_flag got=%0b exp=0", err_flag); end
        checks++; if (err_pos !== 3'd0) begin failures++; $display("FAIL reset_err_pos got=%0d exp=0", err_pos); end
        checks++; if (corr_cnt !== 16'd0) begin failures++; $display("FAIL reset_corr_cnt got=%0d exp=0", corr_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        rst_n = 1'b1;
        exp1 = 0; exp2 = 0;
    endtask

    task automatic test_clean;
        in_valid = 1'b1; code_in = 7'h55;
        tick;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clean_latency got=%0b exp=0", out_valid); end
        tick;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL clean_valid got=%0b exp=1", out_valid); end
        checks++; if (data_out !== 4'b1011) begin failures++; $display("FAIL clean_data got=%0b exp=1011", data_out); end
        checks++; if (err_flag !== 1'b0 || err_pos !== 3'd0) begin
            failures++; $display("FAIL clean_flags got=%0b/%0d exp=0/0", err_flag, err_pos);
        end
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clean_drain got=%0b exp=0", out_valid); end
        checks++; if (int'(corr_cnt) !== 0) begin failures++; $display("FAIL clean_cnt got=%0d exp=0", corr_cnt); end
    endtask

    // Every single-bit flip of 7'h55, including parity-only (i=0,1,3) and 7'h75 (i=5).
    task automatic test_single;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; code_in = 7'h55 ^ 7'(1 << i);
            tick;
            in_valid = 1'b0;
            tick;
            checks++; if (out_valid !== 1'b1 || data_out !== 4'b1011) begin
                failures++; $display("FAIL single_data bit=%0d got=%0b/%0b exp=1/1011", i, out_valid, data_out);
            end
            checks++; if (err_flag !== 1'b1 || err_pos !== 3'(i + 1)) begin
                failures++; $display("FAIL single_flags bit=%0d got=%0b/%0d exp=1/%0d", i, err_flag, err_pos, i + 1);
            end
            tick;
            exp1++; exp2 = (exp2 < 3) ? exp2 + 1 : 3;
            checks++; if (int'(corr_cnt) !== (CNT_EN ? exp1 : 0)) begin
                failures++; $display("FAIL single_cnt bit=%0d got=%0d exp=%0d", i, corr_cnt, CNT_EN ? exp1 : 0);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] words [4];
        logic [3:0] ed [4];
        logic       ef [4];
        logic [2:0] ep [4];
        logic [3:0] hd;
        logic       hf;
        logic [2:0] hp;
        int  sent = 0, rcv = 0, stall_left = 0;
        bit  stalled_once = 0, acc;
        words = '{7'h55, 7'h75, 7'h7F, 7'h54};
        ed = '{4'b1011, 4'b1011, 4'b1111, 4'b1011};
        ef = '{1'b0, 1'b1, 1'b0, 1'b1};
        ep = '{3'd0, 3'd6, 3'd0, 3'd1};
        hd = '0; hf = 1'b0; hp = '0;
        for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
            if (out_valid && !stalled_once) begin
                stalled_once = 1; stall_left = 3;
                hd = data_out; hf = err_flag; hp = err_pos;
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < 4);
            code_in   = (sent < 4) ? words[sent] : 7'h00;
            #1;
            if (stall_left > 0) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%0b exp=0", in_ready); end
                checks++; if (out_valid !== 1'b1 || data_out !== hd || err_flag !== hf || err_pos !== hp) begin
                    failures++; $display("FAIL stall_hold got=%0b/%0b/%0b/%0d exp=1/%0b/%0b/%0d",
                                         out_valid, data_out, err_flag, err_pos, hd, hf, hp);
                end
                stall_left--;
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                checks++;
                if (rcv >= 4) begin
                    failures++; $display("FAIL stream_extra got=%0d exp<4", rcv);
                end else if (data_out !== ed[rcv] || err_flag !== ef[rcv] || err_pos !== ep[rcv]) begin
                    failures++; $display("FAIL stream_word%0d got=%0b/%0b/%0d exp=%0b/%0b/%0d",
                                         rcv, data_out, err_flag, err_pos, ed[rcv], ef[rcv], ep[rcv]);
                end
                if (rcv < 4 && ef[rcv]) begin
                    exp1++; exp2 = (exp2 < 3) ? exp2 + 1 : 3;
                end
                rcv++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        checks++; if (rcv !== 4 || sent !== 4) begin
            failures++; $display("FAIL stream_count got=%0d/%0d exp=4/4", sent, rcv);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_no_dup got=%0b exp=0", out_valid); end
        checks++; if (int'(corr_cnt) !== (CNT_EN ? exp1 : 0)) begin
            failures++; $display("FAIL stream_cnt got=%0d exp=%0d", corr_cnt, CNT_EN ? exp1 : 0);
        end
    endtask

    task automatic test_saturation;
        rst_n = 1'b0; tick; rst_n = 1'b1;
        exp1 = 0; exp2 = 0;
        out_ready = 1'b1; in_valid = 1'b1; code_in = 7'h75;
        for (int i = 0; i < 5; i++) tick;
        in_valid = 1'b0;
        tick; tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_drain got=%0b exp=0", out_valid); end
        checks++; if (int'(corr_cnt2) !== (CNT_EN ? 3 : 0)) begin
            failures++; $display("FAIL sat_cnt2 got=%0d exp=%0d", corr_cnt2, CNT_EN ? 3 : 0);
        end
        checks++; if (int'(corr_cnt) !== (CNT_EN ? 5 : 0)) begin
            failures++; $display("FAIL sat_cnt16 got=%0d exp=%0d", corr_cnt, CNT_EN ? 5 : 0);
        end
        in_valid = 1'b1; code_in = 7'h75;
        tick;
        in_valid = 1'b0;
        tick;
        cnt_clr = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || err_flag !== 1'b1) begin
            failures++; $display("FAIL clr_pending got=%0b/%0b exp=1/1", out_valid, err_flag);
        end
        tick;
        cnt_clr = 1'b0;
        checks++; if (corr_cnt !== 16'd0 || corr_cnt2 !== 2'd0) begin
            failures++; $display("FAIL clr_wins got=%0d/%0d exp=0/0", corr_cnt, corr_cnt2);
        end
        exp1 = 0; exp2 = 0;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1;
        in_valid = 1'b1; code_in = 7'h75;
        tick;
        code_in = 7'h55;
        tick;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%0b exp=1", out_valid); end
        rst_n = 1'b0; in_valid = 1'b0;
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%0b exp=0", out_valid); end
        checks++; if (corr_cnt !== 16'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", corr_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%0b exp=1", in_ready); end
        rst_n = 1'b1;
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_s1_dropped got=%0b exp=0", out_valid); end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_single;
        test_back_to_back;
        test_saturation;
        test_reset_midstream;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
